// File: rtl/seq_adder48_pkg.sv
// Shared widths, FSM state encoding and chunk index type for the 48-bit sequential adder.
// No logic here; latency and backpressure are defined by the modules that import it.
package seq_adder48_pkg;

    localparam int CHUNK_W    = 12;
    localparam int NUM_CHUNKS = 4;
    localparam int RESULT_W   = CHUNK_W * NUM_CHUNKS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_CHUNK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [1:0] chunk_idx_t;

endpackage

// File: rtl/chunk_adder12.sv
// Combinational 12-bit adder with carry in/out; zero latency.
// No backpressure: a pure function of its inputs.
module chunk_adder12
    import seq_adder48_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout
);

    logic [CHUNK_W:0] w_sum13;

    assign w_sum13 = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
    assign sum     = w_sum13[CHUNK_W-1:0];
    assign cout    = w_sum13[CHUNK_W];

endmodule

// File: rtl/seq_adder48.sv
// Adds two 48-bit operands delivered as four 12-bit chunks (LSB first); resultReady pulses 6 clocks after start.
// No backpressure: starts are ignored while busy, and outBus holds until the next result.
module seq_adder48
    import seq_adder48_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHUNK_W-1:0]  inBusA,
    input  logic [CHUNK_W-1:0]  inBusB,
    input  logic                startChunks,
    output logic                resultReady,
    output logic [RESULT_W-1:0] outBus
);

    state_t              r_state;
    chunk_idx_t          r_cnt;
    logic                r_carry;
    logic [RESULT_W-1:0] r_acc;
    logic [RESULT_W-1:0] r_out;
    logic                r_ready;

    logic [CHUNK_W-1:0]  w_sum;
    logic                w_cout;

    chunk_adder12 u_add (
        .a    (inBusA),
        .b    (inBusB),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Accumulation lives in r_acc so outBus stays stable during the next transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_out   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (startChunks) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_acc   <= '0;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_CHUNK;
                    r_cnt   <= '0;
                end
                ST_CHUNK: begin
                    r_acc[int'(r_cnt)*CHUNK_W +: CHUNK_W] <= w_sum;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 2'd1;
                    if (r_cnt == chunk_idx_t'(NUM_CHUNKS - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_out   <= r_acc;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign outBus      = r_out;
    assign resultReady = r_ready;

endmodule

// File: tb/tb_seq_adder48.sv
// Directed-vector bench for seq_adder48: each scenario task drives a transfer and checks timing and sum.
module tb_seq_adder48;

    logic        clk;
    logic        rst_n;
    logic [11:0] inBusA;
    logic [11:0] inBusB;
    logic        startChunks;
    logic        resultReady;
    logic [47:0] outBus;

    int n_checks;
    int n_fail;

    seq_adder48 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inBusA      (inBusA),
        .inBusB      (inBusB),
        .startChunks (startChunks),
        .resultReady (resultReady),
        .outBus      (outBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge; returns 1 time unit after the 4th chunk edge (N+5).
    task automatic send(input logic [47:0] a, input logic [47:0] b, input bit poke_start);
        startChunks = 1'b1;
        inBusA = 'x;
        inBusB = 'x;
        @(posedge clk); #1;
        startChunks = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            inBusA      = a[k*12 +: 12];
            inBusB      = b[k*12 +: 12];
            startChunks = poke_start && (k == 1);
            @(posedge clk); #1;
        end
        startChunks = 1'b0;
        inBusA = 'x;
        inBusB = 'x;
    endtask

    task automatic test_reset();
        int pulses;
        rst_n = 1'b0;
        startChunks = 1'b0;
        inBusA = '0;
        inBusB = '0;
        #2;
        n_checks++;
        if (outBus !== 48'h0) begin
            n_fail++; $display("FAIL reset_out: outBus=%h expected %h", outBus, 48'h0);
        end
        n_checks++;
        if (resultReady !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: resultReady=%b expected 0", resultReady);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resultReady === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL reset_no_pulse: ready pulses=%0d expected 0", pulses);
        end
    endtask

    task automatic test_basic();
        send(48'h004_003_002_001, 48'h004_003_002_001, 1'b0);
        n_checks++;
        if (resultReady !== 1'b0) begin
            n_fail++; $display("FAIL basic_early: resultReady=%b expected 0 at start+5", resultReady);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1) begin
            n_fail++; $display("FAIL basic_ready: resultReady=%b expected 1 at start+6", resultReady);
        end
        n_checks++;
        if (outBus !== 48'h008_006_004_002) begin
            n_fail++; $display("FAIL basic_sum: outBus=%h expected %h", outBus, 48'h008_006_004_002);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse: resultReady=%b expected 0 after one cycle", resultReady);
        end
    endtask

    task automatic test_single_low();
        send(48'h000_000_000_001, 48'h000_000_000_002, 1'b0);
        n_checks++;
        if (outBus !== 48'h008_006_004_002) begin
            n_fail++; $display("FAIL single_hold: outBus=%h expected %h", outBus, 48'h008_006_004_002);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1 || outBus !== 48'd3) begin
            n_fail++; $display("FAIL single_sum: ready=%b outBus=%h expected 1/%h", resultReady, outBus, 48'd3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mixed();
        send({12'd19, 12'd299, 12'd144, 12'd34}, {12'd2000, 12'd29, 12'd255, 12'd66}, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1 || outBus !== 48'h7E3_148_18F_064) begin
            n_fail++; $display("FAIL mixed_sum: ready=%b outBus=%h expected 1/%h", resultReady, outBus, 48'h7E3_148_18F_064);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_carry();
        send(48'h000_000_000_FFF, 48'h000_000_000_001, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1 || outBus !== 48'h000_000_001_000) begin
            n_fail++; $display("FAIL carry_sum: ready=%b outBus=%h expected 1/%h", resultReady, outBus, 48'h000_000_001_000);
        end
        @(posedge clk); #1;
        send(48'hFFF_FFF_FFF_FFF, 48'h000_000_000_001, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1 || outBus !== 48'h0) begin
            n_fail++; $display("FAIL wrap_sum: ready=%b outBus=%h expected 1/%h", resultReady, outBus, 48'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int pulses;
        send(48'h400_300_200_100, 48'h089_067_045_023, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1 || outBus !== 48'h489_367_245_123) begin
            n_fail++; $display("FAIL poke_sum: ready=%b outBus=%h expected 1/%h", resultReady, outBus, 48'h489_367_245_123);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (resultReady === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL poke_extra: extra ready pulses=%0d expected 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        startChunks = 1'b1;
        @(posedge clk); #1;
        startChunks = 1'b0;
        @(posedge clk); #1;
        inBusA = 12'h111; inBusB = 12'h222;
        @(posedge clk); #1;
        inBusA = 12'h333; inBusB = 12'h444;
        @(posedge clk); #1;
        inBusA = 12'h555; inBusB = 12'h666;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (outBus !== 48'h0 || resultReady !== 1'b0) begin
            n_fail++; $display("FAIL midreset_out: ready=%b outBus=%h expected 0/%h", resultReady, outBus, 48'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        inBusA = 'x; inBusB = 'x;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (resultReady === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || outBus !== 48'h0) begin
            n_fail++; $display("FAIL midreset_quiet: pulses=%0d outBus=%h expected 0/%h", pulses, outBus, 48'h0);
        end
        send(48'h000_ABC_7FF_800, 48'h000_001_000_800, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1 || outBus !== 48'h000_ABD_800_000) begin
            n_fail++; $display("FAIL midreset_fresh: ready=%b outBus=%h expected 1/%h", resultReady, outBus, 48'h000_ABD_800_000);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        send(48'h007_005_003_001, 48'h008_006_004_002, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1 || outBus !== 48'h00F_00B_007_003) begin
            n_fail++; $display("FAIL b2b_first: ready=%b outBus=%h expected 1/%h", resultReady, outBus, 48'h00F_00B_007_003);
        end
        // Start is driven during the ready cycle, so it is sampled in the IDLE cycle right after DONE.
        send(48'h000_000_000_FFF, 48'h000_000_000_FFF, 1'b0);
        n_checks++;
        if (resultReady !== 1'b0 || outBus !== 48'h00F_00B_007_003) begin
            n_fail++; $display("FAIL b2b_hold: ready=%b outBus=%h expected 0/%h", resultReady, outBus, 48'h00F_00B_007_003);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b1 || outBus !== 48'h000_000_001_FFE) begin
            n_fail++; $display("FAIL b2b_second: ready=%b outBus=%h expected 1/%h", resultReady, outBus, 48'h000_000_001_FFE);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resultReady !== 1'b0) begin
            n_fail++; $display("FAIL b2b_pulse: resultReady=%b expected 0", resultReady);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_single_low();
        test_mixed();
        test_carry();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
